// File: rtl/miner_slave_regs.sv
// rtl/miner_slave_regs.sv - host register bank and command FSM in front of the hash core
//
// Purpose: holds the 256-bit target and 608-bit header written by the host,
// sequences start/abort pulses to the hash core, captures the winning nonce
// and returns status/nonce on registered host reads.
// Optional feature: define MINER_IRQ_EN to add the irq output.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   slaveAddr         word address
//   slaveWriteData    write data
//   slaveWrite        write strobe (qualified by slaveChipSelect)
//   slaveRead         read strobe (qualified by slaveChipSelect)
//   slaveChipSelect   block select
//   slaveReadData     registered read data, valid 1 cycle after the strobe
//   core_target       target to core
//   core_msg          message header to core
//   core_start        1-cycle start pulse
//   core_abort        1-cycle abort pulse
//   core_found        1-cycle pulse, core_nonce valid
//   core_nonce        winning nonce
//   irq               (MINER_IRQ_EN only) set on entry to FOUND
module miner_slave_regs #(
  parameter int ADDR_W       = 5,
  parameter int TARGET_WORDS = 8,
  parameter int MSG_WORDS    = 19
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         slaveAddr,
  input  logic [31:0]               slaveWriteData,
  input  logic                      slaveWrite,
  input  logic                      slaveRead,
  input  logic                      slaveChipSelect,
  output logic [31:0]               slaveReadData,
  output logic [32*TARGET_WORDS-1:0] core_target,
  output logic [32*MSG_WORDS-1:0]   core_msg,
  output logic                      core_start,
  output logic                      core_abort,
  input  logic                      core_found,
  input  logic [31:0]               core_nonce
`ifdef MINER_IRQ_EN
  ,
  output logic                      irq
`endif
);

  localparam logic [31:0] STATUS_ADDR = 32'd0;
  localparam logic [31:0] CMD_ADDR    = 32'd1;
  localparam logic [31:0] TGT_BASE    = 32'd2;
  localparam logic [31:0] NONCE_ADDR  = TGT_BASE + 32'(TARGET_WORDS);
  localparam logic [31:0] MSG_BASE    = NONCE_ADDR + 32'd1;
  localparam logic [31:0] MSG_END     = MSG_BASE + 32'(MSG_WORDS);
  localparam int          TGT_IW      = (TARGET_WORDS > 1) ? $clog2(TARGET_WORDS) : 1;
  localparam int          MSG_IW      = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TGT    = 2'd1,
    S_MINING = 2'd2,
    S_FOUND  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [TARGET_WORDS-1:0][31:0] target_q;
  logic [MSG_WORDS-1:0][31:0]    msg_q;
  logic [31:0]                   nonce_q;

  logic              wr_en, rd_en;
  logic [31:0]       addr_ext, tgt_off, msg_off;
  logic              in_tgt, in_msg, cmd_wr;
  logic [TGT_IW-1:0] tgt_idx;
  logic [MSG_IW-1:0] msg_idx;
  logic [1:0]        cmd;
  logic              start_d, abort_d, found_ok, cmd_ok;
  logic [31:0]       rd_data;

  assign wr_en    = slaveChipSelect & slaveWrite;
  assign rd_en    = slaveChipSelect & slaveRead;
  assign addr_ext = 32'(slaveAddr);
  assign tgt_off  = addr_ext - TGT_BASE;
  assign msg_off  = addr_ext - MSG_BASE;
  assign tgt_idx  = tgt_off[TGT_IW-1:0];
  assign msg_idx  = msg_off[MSG_IW-1:0];
  assign in_tgt   = (addr_ext >= TGT_BASE) && (addr_ext < NONCE_ADDR);
  assign in_msg   = (addr_ext >= MSG_BASE) && (addr_ext < MSG_END);
  assign cmd_wr   = wr_en && (addr_ext == CMD_ADDR);
  assign cmd      = slaveWriteData[1:0];

  assign core_target = target_q;
  assign core_msg    = msg_q;

  // Command decode and found handling. An abort in the same cycle as
  // core_found takes priority so the nonce of an aborted run is never kept.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    found_ok = 1'b0;
    cmd_ok   = 1'b0;
    if (cmd_wr) begin
      case (cmd)
        2'd1: if (state_q != S_MINING) begin
          state_d = S_TGT;
          cmd_ok  = 1'b1;
        end
        2'd2: if (state_q != S_MINING) begin
          state_d = S_MINING;
          start_d = 1'b1;
          cmd_ok  = 1'b1;
        end
        2'd3: if (state_q == S_MINING) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
          cmd_ok  = 1'b1;
        end
        default: ;
      endcase
    end
    if (core_found && (state_q == S_MINING) && !abort_d) begin
      state_d  = S_FOUND;
      found_ok = 1'b1;
    end
  end

  // Read mux sees the current (pre-write) register contents.
  always_comb begin
    rd_data = 32'd0;
    if (addr_ext == STATUS_ADDR) begin
      rd_data = {30'd0, state_q};
    end else if (in_tgt) begin
      rd_data = target_q[tgt_idx];
    end else if (addr_ext == NONCE_ADDR) begin
      rd_data = nonce_q;
    end else if (in_msg) begin
      rd_data = msg_q[msg_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      target_q      <= '0;
      msg_q         <= '0;
      nonce_q       <= 32'd0;
      slaveReadData <= 32'd0;
      core_start    <= 1'b0;
      core_abort    <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_start <= start_d;
      core_abort <= abort_d;
      if (found_ok) begin
        nonce_q <= core_nonce;
      end
      if (rd_en) begin
        slaveReadData <= rd_data;
      end
      // Core inputs are frozen while mining.
      if (wr_en && (state_q != S_MINING)) begin
        if (in_tgt) begin
          target_q[tgt_idx] <= slaveWriteData;
        end
        if (in_msg) begin
          msg_q[msg_idx] <= slaveWriteData;
        end
      end
    end
  end

`ifdef MINER_IRQ_EN
  logic irq_set, irq_clr;
  assign irq_set = (state_d == S_FOUND) && (state_q != S_FOUND);
  assign irq_clr = (rd_en && (addr_ext == STATUS_ADDR)) || cmd_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (irq_set) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_miner_slave_regs.sv
// tb/tb_miner_slave_regs.sv - scoreboard bench for miner_slave_regs
module tb_miner_slave_regs;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   slaveAddr = '0;
  logic [31:0]  slaveWriteData = '0;
  logic         slaveWrite = 1'b0;
  logic         slaveRead = 1'b0;
  logic         slaveChipSelect = 1'b0;
  logic [31:0]  slaveReadData;
  logic [255:0] core_target;
  logic [607:0] core_msg;
  logic         core_start;
  logic         core_abort;
  logic         core_found = 1'b0;
  logic [31:0]  core_nonce = '0;
`ifdef MINER_IRQ_EN
  logic         irq;
`endif

  miner_slave_regs dut (
    .clk             (clk),
    .rst             (rst),
    .slaveAddr       (slaveAddr),
    .slaveWriteData  (slaveWriteData),
    .slaveWrite      (slaveWrite),
    .slaveRead       (slaveRead),
    .slaveChipSelect (slaveChipSelect),
    .slaveReadData   (slaveReadData),
    .core_target     (core_target),
    .core_msg        (core_msg),
    .core_start      (core_start),
    .core_abort      (core_abort),
    .core_found      (core_found),
    .core_nonce      (core_nonce)
`ifdef MINER_IRQ_EN
    ,
    .irq             (irq)
`endif
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  int start_cnt = 0;
  int abort_cnt = 0;
  logic [31:0] exp_q[$];
  logic        rd_valid;

  task automatic check(input string name, input logic [607:0] got, input logic [607:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Monitor: a read strobe seen at a rising edge means slaveReadData is valid
  // after that edge; compare it against the oldest expected value.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_valid <= 1'b0;
    else     rd_valid <= slaveChipSelect & slaveRead;
  end

  always @(negedge clk) begin
    if (core_start) start_cnt++;
    if (core_abort) abort_cnt++;
    if (rd_valid && !rst) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", {576'd0, slaveReadData}, 608'd0 - 608'd1);
      end else begin
        check("read_data", {576'd0, slaveReadData}, {576'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    slaveAddr = a; slaveWriteData = d; slaveChipSelect = 1'b1; slaveWrite = 1'b1;
    @(negedge clk); #1;
    slaveWrite = 1'b0; slaveChipSelect = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    slaveAddr = a; slaveChipSelect = 1'b1; slaveRead = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk); #1;
    slaveRead = 1'b0; slaveChipSelect = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic found_pulse(input logic [31:0] n);
    core_found = 1'b1; core_nonce = n;
    @(negedge clk); #1;
    core_found = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_rdata", {576'd0, slaveReadData}, 608'd0);
    check("reset_target", {352'd0, core_target}, 608'd0);
    check("reset_start", {607'd0, core_start}, 608'd0);
    rst = 1'b0;
    settle();
    rd(5'd0, 32'd0);
    rd(5'd10, 32'd0);

    // Target load, with a same-cycle read/write returning the old value.
    for (int i = 2; i <= 9; i++) wr(5'(i), (i == 9) ? 32'h1000_0000 : 32'd0);
    slaveAddr = 5'd3; slaveWriteData = 32'h0000_AAAA;
    slaveChipSelect = 1'b1; slaveWrite = 1'b1; slaveRead = 1'b1;
    exp_q.push_back(32'd0);
    @(negedge clk); #1;
    slaveWrite = 1'b0; slaveRead = 1'b0; slaveChipSelect = 1'b0;
    rd(5'd3, 32'h0000_AAAA);
    wr(5'd3, 32'd0);
    rd(5'd1, 32'd0);
    rd(5'd30, 32'd0);
    wr(5'd1, 32'd1);
    check("target_commit", {352'd0, core_target}, {352'd0, 32'h1000_0000, 224'd0});
    rd(5'd0, 32'd1);

    // Message load and start.
    for (int i = 0; i < 19; i++) wr(5'(11 + i), 32'h100 + 32'(i));
    check("msg_word0", {576'd0, core_msg[31:0]}, {576'd0, 32'h100});
    check("msg_word18", {576'd0, core_msg[607:576]}, {576'd0, 32'h112});
    wr(5'd1, 32'd2);
    settle(); settle();
    check("start_once", 608'(start_cnt), 608'd1);
    rd(5'd0, 32'd2);

    found_pulse(32'd42);
`ifdef MINER_IRQ_EN
    check("irq_set", {607'd0, irq}, {607'd0, 1'b1});
`endif
    rd(5'd0, 32'd3);
`ifdef MINER_IRQ_EN
    check("irq_clr_read", {607'd0, irq}, 608'd0);
`endif
    rd(5'd10, 32'd42);

    // Restart from FOUND: nonce persists, then protections while mining.
    wr(5'd1, 32'd2);
    settle();
    check("start_from_found", 608'(start_cnt), 608'd2);
    rd(5'd10, 32'd42);
    wr(5'd11, 32'hDEAD_BEEF);
    wr(5'd2, 32'h5);
    check("msg_protect", {576'd0, core_msg[31:0]}, {576'd0, 32'h100});
    check("tgt_protect", {576'd0, core_target[31:0]}, 608'd0);
    wr(5'd1, 32'd2);
    settle(); settle();
    check("no_second_start", 608'(start_cnt), 608'd2);
    wr(5'd1, 32'd1);
    rd(5'd0, 32'd2);

    // Abort and found in the same cycle: abort wins.
    core_found = 1'b1; core_nonce = 32'd99;
    wr(5'd1, 32'd3);
    core_found = 1'b0;
    settle();
    check("abort_pulse", 608'(abort_cnt), 608'd1);
    rd(5'd0, 32'd0);
    rd(5'd10, 32'd42);
    wr(5'd1, 32'd3);
    settle(); settle();
    check("abort_idle_noop", 608'(abort_cnt), 608'd1);

    // Asynchronous reset mid-mining.
    wr(5'd1, 32'd2);
    rd(5'd10, 32'd42);
    #2 rst = 1'b1;
    #1;
    check("arst_rdata", {576'd0, slaveReadData}, 608'd0);
    check("arst_target", {352'd0, core_target}, 608'd0);
    check("arst_msg", core_msg, 608'd0);
    check("arst_pulses", {606'd0, core_start, core_abort}, 608'd0);
    repeat (2) settle();
    check("arst_no_abort", 608'(abort_cnt), 608'd1);
    rst = 1'b0;
    settle();
    rd(5'd0, 32'd0);
    rd(5'd10, 32'd0);
    wr(5'd1, 32'd2);
    settle();
    check("start_after_rst", 608'(start_cnt), 608'd4);
    rd(5'd0, 32'd2);

`ifdef MINER_IRQ_EN
    found_pulse(32'd7);
    check("irq_set2", {607'd0, irq}, {607'd0, 1'b1});
    wr(5'd1, 32'd2);
    check("irq_clr_cmd", {607'd0, irq}, 608'd0);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) settle();
    check("queue_drained", 608'(exp_q.size()), 608'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
